// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity selectors and the
// smallest bit period the serializer will run with.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_tx_edge_counter.sv
// Bit-period timer for the UART transmitter: counts clock edges inside the
// current bit and flags the last edge of that bit.
module uart_tx_edge_counter #(
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   CLK_TX,
    input  logic                   RST_TX,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [PRESC_WIDTH-1:0] presc_q,
    output logic                   bit_end
);

    logic [PRESC_WIDTH-1:0] edge_cnt;

    assign bit_end = enable && (edge_cnt == (presc_q - PRESC_WIDTH'(1)));

    // Count 0..presc_q-1 while a frame runs, restarting on each new frame.
    always_ff @(posedge CLK_TX or posedge RST_TX) begin
        if (RST_TX) begin
            edge_cnt <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
        end else if (enable) begin
            if (bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESC_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: takes a byte over a valid/ack handshake and
// emits start, LSB-first data, optional parity and stop bits on TX_OUT.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   CLK_TX,
    input  logic                   RST_TX,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   DATA_VALID,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   TX_OUT,
    output logic                   TX_ACK,
    output logic                   busy
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]       LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRESC_WIDTH-1:0] PRESC_MIN = PRESC_WIDTH'(MIN_PRESCALE);

    tx_state_t              state;
    tx_state_t              state_n;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   par_en_q;
    logic                   par_bit_q;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BIT_W-1:0]       bit_cnt_n;
    logic                   tx_n;
    logic                   accept;
    logic                   bit_end;
    logic                   counting;

    assign counting = (state != IDLE);

    uart_tx_edge_counter #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_edge_counter (
        .CLK_TX (CLK_TX),
        .RST_TX (RST_TX),
        .clear  (accept),
        .enable (counting),
        .presc_q(presc_q),
        .bit_end(bit_end)
    );

    // Next state, bit index and the line level for the coming cycle; TX_OUT
    // is registered from the next state so the start bit begins on the
    // accepting edge.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        tx_n      = 1'b1;
        accept    = DATA_VALID && ((state == IDLE) || ((state == STOP) && bit_end));

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = START;
                    bit_cnt_n = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        state_n   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (accept) begin
                        state_n   = START;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
            end
        endcase

        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_q[bit_cnt_n];
            PARITY:  tx_n = par_bit_q;
            default: tx_n = 1'b1;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge CLK_TX or posedge RST_TX) begin
        if (RST_TX) begin
            state   <= IDLE;
            bit_cnt <= '0;
            TX_OUT  <= 1'b1;
            TX_ACK  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            TX_OUT  <= tx_n;
            TX_ACK  <= accept;
            busy    <= (state_n != IDLE);
        end
    end

    // Frame configuration captured at acceptance; parity is fixed here so
    // later changes on P_DATA or PAR_TYP cannot alter the frame.
    always_ff @(posedge CLK_TX or posedge RST_TX) begin
        if (RST_TX) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= PRESC_MIN;
        end else if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
            presc_q   <= (prescale < PRESC_MIN) ? PRESC_MIN : prescale;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: each frame's expected line
// waveform is built from the frame format and compared cycle by cycle.
module tb_uart_tx_serializer;

    logic       CLK_TX = 1'b0;
    logic       RST_TX;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       TX_ACK;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        exp_q[$];

    uart_tx_serializer #(
        .DATA_WIDTH (8),
        .PRESC_WIDTH(6)
    ) dut (
        .CLK_TX    (CLK_TX),
        .RST_TX    (RST_TX),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .prescale  (prescale),
        .TX_OUT    (TX_OUT),
        .TX_ACK    (TX_ACK),
        .busy      (busy)
    );

    always #5 CLK_TX = ~CLK_TX;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed no end, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK_TX);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level per clock: each frame bit repeated for the
    // effective bit period, parity from a plain count of ones.
    task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [5:0] ps);
        int   eff;
        int   ones;
        logic bits[$];
        eff  = (ps < 4) ? 4 : int'(ps);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
        bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[b]) begin
            for (int r = 0; r < eff; r++) exp_q.push_back(bits[b]);
        end
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 200; i++) begin
            step();
            if (TX_ACK === 1'b1) break;
        end
        chk({tag, "_ack"}, TX_ACK, 1);
    endtask

    // Compare the whole frame starting at the current (first start-bit) cycle.
    task automatic check_frame(input string tag, input bit disturb);
        int len;
        len = exp_q.size();
        for (int k = 0; k < len; k++) begin
            chk({tag, "_tx"}, TX_OUT, exp_q[k]);
            chk({tag, "_busy"}, busy, 1);
            if (k > 0) chk({tag, "_noack"}, TX_ACK, 0);
            if (disturb) begin
                if (k == 1) begin
                    prescale = 6'($urandom_range(0, 63));
                    PAR_EN   = ~PAR_EN;
                    PAR_TYP  = ~PAR_TYP;
                    P_DATA   = 8'($urandom);
                end
                if (k == len / 2)     DATA_VALID = 1'b1;
                if (k == len / 2 + 1) DATA_VALID = 1'b0;
            end
            step();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle_tx"}, TX_OUT, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_ack"}, TX_ACK, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [5:0] ps, input bit disturb);
        build_frame(d, pe, pt, ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = ps;
        DATA_VALID = 1'b1;
        wait_ack(tag);
        DATA_VALID = 1'b0;
        check_frame(tag, disturb);
        check_idle(tag);
        step();
    endtask

    initial begin
        RST_TX     = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;
        #3;
        check_idle("reset");
        step();
        step();
        RST_TX = 1'b0;
        step();
        check_idle("post_reset");

        run_frame("a5_np", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
        run_frame("03_even", 8'h03, 1'b1, 1'b0, 6'd8, 1'b0);
        run_frame("03_odd", 8'h03, 1'b1, 1'b1, 6'd8, 1'b0);

        // Back-to-back: valid held across the first frame.
        build_frame(8'h55, 1'b0, 1'b0, 6'd8);
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;
        DATA_VALID = 1'b1;
        wait_ack("b2b1");
        P_DATA = 8'hAA;
        check_frame("b2b1", 1'b0);
        chk("b2b2_ack", TX_ACK, 1);
        chk("b2b2_busy", busy, 1);
        DATA_VALID = 1'b0;
        build_frame(8'hAA, 1'b0, 1'b0, 6'd8);
        check_frame("b2b2", 1'b0);
        check_idle("b2b2");
        step();

        run_frame("clamp2", 8'h96, 1'b1, 1'b0, 6'd2, 1'b1);
        run_frame("clamp0", 8'h3C, 1'b0, 1'b0, 6'd0, 1'b0);
        run_frame("midcfg", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b1);

        // Asynchronous reset in the middle of the data bits.
        build_frame(8'h00, 1'b0, 1'b0, 6'd5);
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        prescale   = 6'd5;
        DATA_VALID = 1'b1;
        wait_ack("rstmid");
        DATA_VALID = 1'b0;
        for (int k = 0; k < 15; k++) step();
        chk("rstmid_pre_tx", TX_OUT, exp_q[15]);
        chk("rstmid_pre_busy", busy, 1);
        RST_TX = 1'b1;
        #1;
        check_idle("rstmid");
        step();
        RST_TX = 1'b0;
        step();
        check_idle("rstmid_rel");

        for (int n = 0; n < 12; n++) begin
            run_frame("rand", 8'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 6'($urandom_range(0, 12)),
                      1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
